// File: rtl/sigdelay_taps.sv
// sigdelay_taps: multi-tap programmable delay of the raw signal bundle, one phase-offset copy per correlator chain
module sigdelay_taps #(
    parameter int RADIOS  = 32,
    parameter int TRATE   = 30,
    parameter int CHAINS  = 4,
    parameter int LOOP0   = 3,
    parameter int REVERSE = 1,
    parameter int DEPTH   = 16,
    parameter int TBITS   = $clog2(TRATE),
    parameter int CBITS   = (CHAINS > 1) ? $clog2(CHAINS) : 1,
    parameter int DBITS   = $clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic                       first_i,
    input  logic                       next_i,
    input  logic                       emit_i,
    input  logic                       last_i,
    input  logic [TBITS-1:0]           addr_i,
    input  logic [RADIOS-1:0]          sigi_i,
    input  logic [RADIOS-1:0]          sigq_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [CBITS-1:0]           cfg_chain_i,
    input  logic [DBITS-1:0]           cfg_delay_i,
    output logic                       cfg_error_o,
    output logic [CHAINS-1:0]          valid_o,
    output logic [CHAINS-1:0]          first_o,
    output logic [CHAINS-1:0]          next_o,
    output logic [CHAINS-1:0]          emit_o,
    output logic [CHAINS-1:0]          last_o,
    output logic [CHAINS*TBITS-1:0]    addr_o,
    output logic [CHAINS*RADIOS-1:0]   sigi_o,
    output logic [CHAINS*RADIOS-1:0]   sigq_o
);
    localparam int BASE     = REVERSE ? LOOP0 - 1 : LOOP0 + 1;
    localparam int W        = TBITS + 5 + 2 * RADIOS;
    localparam int PBITS    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW       = DBITS + 1;
    localparam int FLAG_LSB = 2 * RADIOS;
    localparam logic [W-1:0] FMASK = {{(W-5){1'b0}}, 5'b11111} << FLAG_LSB;

    typedef enum logic {IDLE, APPLY} state_t;

    function automatic logic [DBITS-1:0] dflt(input int k);
        return DBITS'(BASE + k * LOOP0);
    endfunction

    logic [W-1:0]     bundle;
    logic [W-1:0]     mem_q [DEPTH];
    logic [PBITS-1:0] wp_q, wp_d;
    logic [DBITS-1:0] delay_q [CHAINS];
    logic [DBITS-1:0] delay_d [CHAINS];
    logic [DBITS-1:0] blank_q [CHAINS];
    logic [DBITS-1:0] blank_d [CHAINS];
    logic [W-1:0]     tap_q [CHAINS];
    logic [W-1:0]     tap_d [CHAINS];
    logic [AW-1:0]    rsum [CHAINS];
    logic [PBITS-1:0] ridx [CHAINS];
    logic [W-1:0]     sel [CHAINS];
    logic [CHAINS-1:0] apply;
    state_t           state_q, state_d;
    logic [CBITS-1:0] req_chain_q, req_chain_d;
    logic [DBITS-1:0] req_delay_q, req_delay_d;
    logic             err_q, err_d;
    logic             accept, req_bad;

    assign bundle = {addr_i, last_i, emit_i, next_i, first_i, valid_i, sigq_i, sigi_i};

    // Request capture: latch and validate the config request when it is accepted
    always_comb begin
        accept      = (state_q == IDLE) && cfg_valid_i;
        req_bad     = (cfg_delay_i == '0) || (cfg_delay_i > DBITS'(DEPTH)) ||
                      ({1'b0, cfg_chain_i} >= (CBITS + 1)'(CHAINS));
        req_chain_d = accept ? cfg_chain_i : req_chain_q;
        req_delay_d = accept ? cfg_delay_i : req_delay_q;
        err_d       = accept && req_bad;
        wp_d        = (wp_q == PBITS'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    end

    // Config FSM next state: every accept costs one APPLY cycle
    always_comb begin
        state_d = accept ? APPLY : IDLE;
    end

    // Config FSM outputs: the error flag is only ever set for the APPLY cycle
    always_comb begin
        cfg_ready_o = (state_q == IDLE);
        cfg_error_o = err_q;
    end

    // Config FSM state register; reset drops any pending request
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            req_chain_q <= '0;
            req_delay_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            req_chain_q <= req_chain_d;
            req_delay_q <= req_delay_d;
        end
    end

    // Per-tap read: slot written D-1 cycles ago, or the live input when D is 1
    always_comb begin
        for (int k = 0; k < CHAINS; k++) begin
            apply[k]   = (state_q == APPLY) && !err_q && (req_chain_q == CBITS'(k));
            delay_d[k] = apply[k] ? req_delay_q : delay_q[k];
            blank_d[k] = apply[k] ? req_delay_q : ((blank_q[k] != '0) ? blank_q[k] - 1'b1 : '0);
            rsum[k]    = AW'(wp_q) + AW'(DEPTH + 1) - AW'(delay_q[k]);
            ridx[k]    = PBITS'((rsum[k] >= AW'(DEPTH)) ? rsum[k] - AW'(DEPTH) : rsum[k]);
            sel[k]     = (delay_q[k] == DBITS'(1)) ? bundle : mem_q[ridx[k]];
            tap_d[k]   = (blank_d[k] != '0) ? (sel[k] & ~FMASK) : sel[k];
        end
    end

    // Circular buffer: written every cycle, contents never reset
    always_ff @(posedge clock) begin
        mem_q[wp_q] <= bundle;
    end

    // Tap state: write pointer, delays, blanking counters and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q <= '0;
            for (int k = 0; k < CHAINS; k++) begin
                delay_q[k] <= dflt(k);
                blank_q[k] <= dflt(k);
                tap_q[k]   <= '0;
            end
        end else begin
            wp_q <= wp_d;
            for (int k = 0; k < CHAINS; k++) begin
                delay_q[k] <= delay_d[k];
                blank_q[k] <= blank_d[k];
                tap_q[k]   <= tap_d[k];
            end
        end
    end

    for (genvar g = 0; g < CHAINS; g++) begin : g_out
        assign sigi_o[g*RADIOS +: RADIOS] = tap_q[g][0 +: RADIOS];
        assign sigq_o[g*RADIOS +: RADIOS] = tap_q[g][RADIOS +: RADIOS];
        assign valid_o[g]                 = tap_q[g][FLAG_LSB];
        assign first_o[g]                 = tap_q[g][FLAG_LSB + 1];
        assign next_o[g]                  = tap_q[g][FLAG_LSB + 2];
        assign emit_o[g]                  = tap_q[g][FLAG_LSB + 3];
        assign last_o[g]                  = tap_q[g][FLAG_LSB + 4];
        assign addr_o[g*TBITS +: TBITS]   = tap_q[g][FLAG_LSB + 5 +: TBITS];
    end
endmodule

// File: tb/tb_sigdelay_taps.sv
// tb_sigdelay_taps: directed checks of default taps, reconfiguration, blanking and rejection
module tb_sigdelay_taps;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         valid_i = 1'b1, first_i = 1'b0, next_i = 1'b0, emit_i = 1'b0, last_i = 1'b0;
    logic [4:0]   addr_i = '0;
    logic [31:0]  sigi_i = '0, sigq_i = '0;
    logic         cfg_valid_i = 1'b0;
    logic         cfg_ready_o;
    logic [1:0]   cfg_chain_i = '0;
    logic [4:0]   cfg_delay_i = '0;
    logic         cfg_error_o;
    logic [3:0]   valid_o, first_o, next_o, emit_o, last_o;
    logic [19:0]  addr_o;
    logic [127:0] sigi_o, sigq_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int base = 0;
    int dly[4];

    sigdelay_taps dut (
        .clock(clock), .reset(reset),
        .valid_i(valid_i), .first_i(first_i), .next_i(next_i), .emit_i(emit_i), .last_i(last_i),
        .addr_i(addr_i), .sigi_i(sigi_i), .sigq_i(sigq_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_chain_i(cfg_chain_i),
        .cfg_delay_i(cfg_delay_i), .cfg_error_o(cfg_error_o),
        .valid_o(valid_o), .first_o(first_o), .next_o(next_o), .emit_o(emit_o), .last_o(last_o),
        .addr_o(addr_o), .sigi_o(sigi_o), .sigq_o(sigq_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        sigi_i = 32'(cyc);
        sigq_i = ~32'(cyc);
        addr_i = 5'(cyc % 30);
    endtask

    task automatic do_reset(input bit with_cfg);
        reset = 1'b1;
        cfg_valid_i = with_cfg;
        cfg_chain_i = 2'd0;
        cfg_delay_i = 5'd7;
        tick();
        reset = 1'b0;
        cfg_valid_i = 1'b0;
        base = cyc;
        dly = '{2, 5, 8, 11};
    endtask

    task automatic test_reset();
        tests++; if (valid_o !== 4'h0) begin fails++; $display("FAIL reset valid_o got %h exp 0", valid_o); end
        tests++; if (first_o !== 4'h0) begin fails++; $display("FAIL reset first_o got %h exp 0", first_o); end
        tests++; if (next_o !== 4'h0) begin fails++; $display("FAIL reset next_o got %h exp 0", next_o); end
        tests++; if (emit_o !== 4'h0) begin fails++; $display("FAIL reset emit_o got %h exp 0", emit_o); end
        tests++; if (last_o !== 4'h0) begin fails++; $display("FAIL reset last_o got %h exp 0", last_o); end
        tests++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL reset ready got %b exp 1", cfg_ready_o); end
        tests++; if (cfg_error_o !== 1'b0) begin fails++; $display("FAIL reset error got %b exp 0", cfg_error_o); end
    endtask

    task automatic test_default();
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (valid_o[k] !== (n >= dly[k])) begin
                    fails++; $display("FAIL default valid k=%0d n=%0d got %b exp %b", k, n, valid_o[k], n >= dly[k]);
                end
                if (n >= dly[k]) begin
                    tests++;
                    if (sigi_o[k*32 +: 32] !== 32'(cyc - dly[k])) begin
                        fails++; $display("FAIL default sigi k=%0d n=%0d got %0d exp %0d", k, n, sigi_o[k*32 +: 32], cyc - dly[k]);
                    end
                    tests++;
                    if (sigq_o[k*32 +: 32] !== ~32'(cyc - dly[k])) begin
                        fails++; $display("FAIL default sigq k=%0d n=%0d got %h", k, n, sigq_o[k*32 +: 32]);
                    end
                    tests++;
                    if (addr_o[k*5 +: 5] !== 5'((cyc - dly[k]) % 30)) begin
                        fails++; $display("FAIL default addr k=%0d n=%0d got %0d exp %0d", k, n, addr_o[k*5 +: 5], (cyc - dly[k]) % 30);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_reconfig();
        cfg_valid_i = 1'b1; cfg_chain_i = 2'd1; cfg_delay_i = 5'd16;
        tests++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL reconfig ready idle got %b exp 1", cfg_ready_o); end
        tick();
        cfg_valid_i = 1'b0;
        tests++; if (cfg_ready_o !== 1'b0) begin fails++; $display("FAIL reconfig ready apply got %b exp 0", cfg_ready_o); end
        tests++; if (cfg_error_o !== 1'b0) begin fails++; $display("FAIL reconfig error got %b exp 0", cfg_error_o); end
        tick();
        dly[1] = 16;
        for (int j = 0; j < 20; j++) begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (valid_o[k] !== ((k != 1) || (j >= 16))) begin
                    fails++; $display("FAIL reconfig valid k=%0d j=%0d got %b", k, j, valid_o[k]);
                end
                if ((k != 1) || (j >= 16)) begin
                    tests++;
                    if (sigi_o[k*32 +: 32] !== 32'(cyc - dly[k])) begin
                        fails++; $display("FAIL reconfig sigi k=%0d j=%0d got %0d exp %0d", k, j, sigi_o[k*32 +: 32], cyc - dly[k]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_delay1();
        cfg_valid_i = 1'b1; cfg_chain_i = 2'd0; cfg_delay_i = 5'd1;
        tick();
        cfg_valid_i = 1'b0;
        tests++; if (valid_o[0] !== 1'b1) begin fails++; $display("FAIL delay1 pre-apply valid got %b exp 1", valid_o[0]); end
        tests++; if (sigi_o[31:0] !== 32'(cyc - 2)) begin fails++; $display("FAIL delay1 pre-apply sigi got %0d exp %0d", sigi_o[31:0], cyc - 2); end
        tick();
        dly[0] = 1;
        tests++; if (valid_o[0] !== 1'b0) begin fails++; $display("FAIL delay1 blank valid got %b exp 0", valid_o[0]); end
        tick();
        tests++; if (valid_o[0] !== 1'b1) begin fails++; $display("FAIL delay1 post valid got %b exp 1", valid_o[0]); end
        tests++; if (sigi_o[31:0] !== 32'(cyc - 1)) begin fails++; $display("FAIL delay1 sigi got %0d exp %0d", sigi_o[31:0], cyc - 1); end
        first_i = 1'b1;
        tick();
        first_i = 1'b0;
        tests++; if (first_o !== 4'b0001) begin fails++; $display("FAIL delay1 first pulse got %b exp 0001", first_o); end
        tick();
        tests++; if (first_o[0] !== 1'b0) begin fails++; $display("FAIL delay1 first end got %b exp 0", first_o[0]); end
    endtask

    task automatic test_reject();
        int rc[3] = '{2, 0, 3};
        int rd[3] = '{0, 17, 31};
        for (int i = 0; i < 3; i++) begin
            cfg_valid_i = 1'b1; cfg_chain_i = 2'(rc[i]); cfg_delay_i = 5'(rd[i]);
            tests++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL reject ready i=%0d got %b exp 1", i, cfg_ready_o); end
            tick();
            cfg_valid_i = 1'b0;
            tests++; if (cfg_error_o !== 1'b1) begin fails++; $display("FAIL reject error pulse i=%0d got %b exp 1", i, cfg_error_o); end
            tests++; if (cfg_ready_o !== 1'b0) begin fails++; $display("FAIL reject ready apply i=%0d got %b exp 0", i, cfg_ready_o); end
            tick();
            tests++; if (cfg_error_o !== 1'b0) begin fails++; $display("FAIL reject error end i=%0d got %b exp 0", i, cfg_error_o); end
            tests++; if (valid_o !== 4'hF) begin fails++; $display("FAIL reject valid i=%0d got %h exp f", i, valid_o); end
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (sigi_o[k*32 +: 32] !== 32'(cyc - dly[k])) begin
                    fails++; $display("FAIL reject sigi i=%0d k=%0d got %0d exp %0d", i, k, sigi_o[k*32 +: 32], cyc - dly[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int rc[4] = '{3, 2, 3, 2};
        int rd[4] = '{12, 3, 13, 4};
        for (int j = 0; j < 20; j++) begin
            cfg_valid_i = (j < 4);
            if (j < 4) begin cfg_chain_i = 2'(rc[j]); cfg_delay_i = 5'(rd[j]); end
            if (j < 5) begin
                tests++;
                if (cfg_ready_o !== (j % 2 == 0)) begin fails++; $display("FAIL b2b ready j=%0d got %b exp %b", j, cfg_ready_o, j % 2 == 0); end
            end
            tests++; if (cfg_error_o !== 1'b0) begin fails++; $display("FAIL b2b error j=%0d got %b exp 0", j, cfg_error_o); end
            tests++;
            if (valid_o[3] !== ((j <= 1) || (j >= 17))) begin
                fails++; $display("FAIL b2b chain3 valid j=%0d got %b", j, valid_o[3]);
            end
            if ((j <= 1) || (j >= 17)) begin
                tests++;
                if (sigi_o[96 +: 32] !== 32'(cyc - ((j <= 1) ? 11 : 13))) begin
                    fails++; $display("FAIL b2b chain3 sigi j=%0d got %0d exp %0d", j, sigi_o[96 +: 32], cyc - ((j <= 1) ? 11 : 13));
                end
            end
            tests++; if (valid_o[2] !== 1'b1) begin fails++; $display("FAIL b2b chain2 valid j=%0d got %b exp 1", j, valid_o[2]); end
            tests++;
            if (sigi_o[64 +: 32] !== 32'(cyc - 8)) begin
                fails++; $display("FAIL b2b chain2 sigi j=%0d got %0d exp %0d", j, sigi_o[64 +: 32], cyc - 8);
            end
            tick();
        end
        cfg_valid_i = 1'b0;
        dly[3] = 13;
    endtask

    task automatic test_reset_mid_blank();
        cfg_valid_i = 1'b1; cfg_chain_i = 2'd2; cfg_delay_i = 5'd12;
        tick();
        cfg_valid_i = 1'b0;
        tick();
        tick();
        tests++; if (valid_o[2] !== 1'b0) begin fails++; $display("FAIL midblank blanked got %b exp 0", valid_o[2]); end
        tick();
        do_reset(1'b1);
        for (int n = 0; n < 14; n++) begin
            if (n == 0) begin
                tests++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL midblank ready got %b exp 1", cfg_ready_o); end
                tests++; if (cfg_error_o !== 1'b0) begin fails++; $display("FAIL midblank error got %b exp 0", cfg_error_o); end
            end
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (valid_o[k] !== (n >= dly[k])) begin
                    fails++; $display("FAIL midblank valid k=%0d n=%0d got %b exp %b", k, n, valid_o[k], n >= dly[k]);
                end
                if (n >= dly[k]) begin
                    tests++;
                    if (sigi_o[k*32 +: 32] !== 32'(cyc - dly[k])) begin
                        fails++; $display("FAIL midblank sigi k=%0d n=%0d got %0d exp %0d", k, n, sigi_o[k*32 +: 32], cyc - dly[k]);
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        tick();
        do_reset(1'b0);
        test_reset();
        test_default();
        test_reconfig();
        test_delay1();
        test_reject();
        test_back_to_back();
        test_reset_mid_blank();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
